// File: rtl/ccg_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package ccg_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int MAX_SETTLE = 15;
    localparam int SETTLE_W   = 4;

    // Width of the packed signature: one N_OUT slice per input pattern.
    function automatic int tt_width(input int n_in, input int n_out);
        return n_out * (1 << n_in);
    endfunction

endpackage

// File: rtl/ccg_sweep_pacer.sv
// Settle pacer: one-cycle sample strobe every SETTLE+1 enabled cycles.
module ccg_sweep_pacer
    import ccg_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic sample
);

    localparam logic [SETTLE_W-1:0] SETTLE_C = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] cnt;

    // Count settle cycles; wrap to zero on the sampling cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == SETTLE_C) ? '0 : cnt + SETTLE_W'(1);
        end
    end

    assign sample = en && (cnt == SETTLE_C);

endmodule

// File: rtl/ccg_truth_table_sweeper.sv
// Truth-table sweeper: steps x through every pattern, samples f after the
// settle time and packs the responses into tt.
// Optional golden compare (golden input, mismatch output) is built only when
// CCG_SWEEP_GOLDEN_EN is defined.
module ccg_truth_table_sweeper
    import ccg_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic [N_IN-1:0]                     x,
    input  logic [N_OUT-1:0]                    f,
    output logic                                busy,
    output logic                                done,
    output logic                                tt_valid,
    output logic [tt_width(N_IN, N_OUT)-1:0]    tt
`ifdef CCG_SWEEP_GOLDEN_EN
    ,
    input  logic [tt_width(N_IN, N_OUT)-1:0]    golden,
    output logic                                mismatch
`endif
);

    localparam int TTW = tt_width(N_IN, N_OUT);
    // One extra bit so the last-pattern compare never aliases through a wrap.
    localparam logic [N_IN:0] LAST_PAT = (N_IN + 1)'((1 << N_IN) - 1);

    sweep_state_t    state, next_state;
    logic [N_IN:0]   pat;
    logic            sample;
    logic            start_acc;
    logic            last_pat;
    logic            run_en;
    logic [TTW-1:0]  tt_next;

    assign last_pat = (pat == LAST_PAT);
    assign run_en   = (state == RUN);
    assign x        = pat[N_IN-1:0];

    ccg_sweep_pacer #(
        .SETTLE (SETTLE)
    ) u_pacer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run_en),
        .clr    (start_acc),
        .sample (sample)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        next_state = state;
        start_acc  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    start_acc  = 1'b1;
                end
            end
            RUN: begin
                if (sample && last_pat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Signature with the current pattern's response merged in on a sample.
    always_comb begin
        tt_next = tt;
        if (sample) begin
            tt_next[int'(pat[N_IN-1:0]) * N_OUT +: N_OUT] = f;
        end
    end

    // Pattern counter, capture register and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat      <= '0;
            tt       <= '0;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
            if (start_acc) begin
                pat      <= '0;
                tt       <= '0;
                tt_valid <= 1'b0;
            end else if (sample) begin
                tt <= tt_next;
                if (last_pat) begin
                    tt_valid <= 1'b1;
                end else begin
                    pat <= pat + (N_IN + 1)'(1);
                end
            end
        end
    end

`ifdef CCG_SWEEP_GOLDEN_EN
    // Compare the completed signature against the reference at the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (start_acc) begin
            mismatch <= 1'b0;
        end else if (sample && last_pat) begin
            mismatch <= (tt_next != golden);
        end
    end
`endif

endmodule
